// File: rtl/mips_pkg.sv
// Shared types and constants for the memory stage: op encoding, FSM states, byte-enable masks.
package mips_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_load(input mem_op_e op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data-path alignment: load extraction/extension, store lane replication,
// byte enables and the alignment check.
module mem_align
  import mips_pkg::*;
(
  input  mem_op_e     op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic        aligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  always_comb begin
    case (addr_i)
      2'd0:    lbyte = rdata_i[7:0];
      2'd1:    lbyte = rdata_i[15:8];
      2'd2:    lbyte = rdata_i[23:16];
      default: lbyte = rdata_i[31:24];
    endcase
    lhalf = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Byte enables follow the access size for loads too, so the bus sees the touched lanes.
  always_comb begin
    aligned_o = 1'b1;
    be_o      = BE_NONE;
    wdata_o   = sdata_i;
    ldata_o   = rdata_i;
    case (op_i)
      MEM_LB, MEM_LBU, MEM_SB: begin
        be_o    = BE_BYTE0 << addr_i;
        wdata_o = {4{sdata_i[7:0]}};
        ldata_o = {{24{(op_i == MEM_LB) & lbyte[7]}}, lbyte};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        aligned_o = ~addr_i[0];
        be_o      = addr_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o   = {2{sdata_i[15:0]}};
        ldata_o   = {{16{(op_i == MEM_LH) & lhalf[15]}}, lhalf};
      end
      MEM_LW, MEM_SW: begin
        aligned_o = (addr_i == 2'b00);
        be_o      = BE_WORD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through, or runs one data-bus
// transaction per load/store with a stall until dmem_ack.
module mem_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_,
  input  logic [4:0]  mem_i_waddr,
  input  logic        mem_i_wreg,
  input  logic [31:0] mem_i_wdata,
  input  logic [3:0]  mem_i_op,
  input  logic [31:0] mem_i_addr,
  input  logic [31:0] mem_i_sdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_req,
  output logic [4:0]  wb_o_waddr,
  output logic        wb_o_wreg,
  output logic [31:0] wb_o_wdata,
  output logic        misalign_exc
);

  mem_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] dwdata_q, dwdata_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mis_q, mis_d;

  mem_op_e     op;
  logic        op_load, op_store;
  logic        aligned;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ldata;

  assign op       = mem_op_e'(mem_i_op);
  assign op_load  = is_load(op);
  assign op_store = is_store(op);

  mem_align u_align (
    .op_i      (op),
    .addr_i    (mem_i_addr[1:0]),
    .sdata_i   (mem_i_sdata),
    .rdata_i   (dmem_rdata),
    .aligned_o (aligned),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .ldata_o   (al_ldata)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    dwdata_d  = dwdata_q;
    waddr_d   = waddr_q;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    mis_d     = 1'b0;
    stall_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_load || op_store) begin
          wreg_d = 1'b0;
          if (aligned) begin
            stall_req = 1'b1;
            state_d   = ST_BUSY;
            req_d     = 1'b1;
            we_d      = op_store;
            addr_d    = {mem_i_addr[31:2], 2'b00};
            be_d      = al_be;
            dwdata_d  = al_wdata;
          end else begin
            mis_d = 1'b1;
          end
        end else begin
          // Unrecognised op codes fall through as NONE.
          waddr_d = mem_i_waddr;
          wreg_d  = mem_i_wreg;
          wdata_d = mem_i_wdata;
        end
      end
      ST_BUSY: begin
        stall_req = ~dmem_ack;
        wreg_d    = 1'b0;
        if (dmem_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          if (op_load) begin
            waddr_d = mem_i_waddr;
            wreg_d  = mem_i_wreg;
            wdata_d = al_ldata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      dwdata_q <= '0;
      waddr_q  <= '0;
      wreg_q   <= 1'b0;
      wdata_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      dwdata_q <= dwdata_d;
      waddr_q  <= waddr_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      mis_q    <= mis_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = dwdata_q;
  assign wb_o_waddr   = waddr_q;
  assign wb_o_wreg    = wreg_q;
  assign wb_o_wdata   = wdata_q;
  assign misalign_exc = mis_q;

endmodule
